uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 16: number of TX FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter DIV_WIDTH, default 16: width of the runtime bit-period divisor.
REQ-003 Port clk, input, 1: clock, all logic on rising edge.
REQ-004 Port reset, input, 1: reset, synchronous, active-high.
REQ-005 Port wr_en, input, 1: push wr_data into FIFO.
REQ-006 Port wr_data, input, 8: byte to enqueue.
REQ-007 Port full, output, 1: FIFO holds FIFO_DEPTH entries.
REQ-008 Port empty, output, 1: FIFO holds 0 entries.
REQ-009 Port level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-010 Port overflow, output, 1: one-cycle pulse when a write is dropped.
REQ-011 Port clk_div, input, DIV_WIDTH: clocks per bit; values 0 and 1 SHALL be treated as 2.
REQ-012 Port data_bits, input, 2: frame data length, 00=5, 01=6, 10=7, 11=8.
REQ-013 Port parity_en, input, 1: append a parity bit.
REQ-014 Port parity_odd, input, 1: 1=odd parity, 0=even parity.
REQ-015 Port two_stop, input, 1: 1=two stop bits, 0=one stop bit.
REQ-016 Port tx_busy, output, 1: high in every non-IDLE state.
REQ-017 Port done, output, 1: one-cycle pulse at the end of each frame.
REQ-018 Port tx, output, 1: serial line, idle high, registered.

Function
REQ-019 A write SHALL be accepted when wr_en=1 and full=0, with full evaluated before the edge; a write while full SHALL be dropped and SHALL pulse overflow on the next cycle.
REQ-020 Simultaneous accepted write and pop SHALL leave level unchanged; full, empty and level SHALL update on the same edge as the FIFO pointers; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 States: IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-022 Each START, DATA, PARITY and STOP state SHALL last exactly the effective divisor in clocks.
REQ-023 In IDLE with empty=0, the edge SHALL pop the head, latch it, latch clk_div, data_bits, parity_en, parity_odd and two_stop, drive tx<=0 and enter START.
REQ-024 Configuration changes mid-frame SHALL NOT affect the current frame.
REQ-025 DATA SHALL send bits LSB first, 5-8 bits per the latched data_bits; unused upper bits SHALL be ignored.
REQ-026 After DATA the FSM SHALL enter PARITY if parity_en=1, otherwise STOP1.
REQ-027 The parity bit SHALL equal the XOR of the transmitted data bits, inverted when parity_odd=1.
REQ-028 STOP1 SHALL go to STOP2 if two_stop=1; otherwise STOP1 (or STOP2) SHALL end the frame.
REQ-029 Stop bits SHALL drive tx=1.
REQ-030 At the final cycle of the last stop bit the FSM SHALL pulse done the next cycle.
REQ-031 At the same edge, if empty=0 the FSM SHALL pop and enter START directly, with no idle gap; otherwise it SHALL enter IDLE.
REQ-032 Earliest latency: a write at edge N into an empty FIFO SHALL produce tx=0 after edge N+1.
REQ-033 tx_busy SHALL be 1 from the edge entering START until the edge returning to IDLE.

Reset
REQ-034 Reset SHALL, at any time including mid-frame, set state=IDLE, tx=1, tx_busy=0, done=0, overflow=0, level=0, empty=1, full=0, and discard all FIFO contents.
REQ-035 Writes presented during reset SHALL be ignored.
REQ-036 An in-flight frame SHALL be truncated after reset with no done pulse.

Verification
REQ-037 clk_div=4, 8N1, write 0xA5 -> tx low 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, high 4 clocks, one done pulse, tx_busy for 40 clocks.
REQ-038 clk_div=3, 7 data bits, odd parity, 2 stop bits, write 0x41 -> 1 start, 7 data, parity=1, 2 stop; 11 bits x 3 clocks = 33 busy clocks.
REQ-039 FIFO_DEPTH=4, five writes on consecutive cycles with the TX FSM held off by reset release timing -> level=4, full=1, fifth write dropped, overflow pulses once; four frames follow back-to-back with no idle cycle between them.
REQ-040 clk_div=0 -> every bit lasts 2 clocks.
REQ-041 Change data_bits mid-frame -> frame length is unchanged, and the next frame uses the new value.
REQ-042 Assert reset mid-DATA with 3 entries queued -> tx=1 and level=0 after the reset edge; no done pulse; no further frames are sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a configurable UART transmitter.
// Frame format (5-8 data bits, optional parity, 1/2 stop bits) and bit period
// are sampled when a byte is popped, so they stay fixed for that whole frame.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  input  logic [DIV_WIDTH-1:0]        clk_div,
  input  logic [1:0]                  data_bits,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  input  logic                        two_stop,
  output logic                        tx_busy,
  output logic                        done,
  output logic                        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  // Per-frame settings captured at pop time.
  typedef struct packed {
    logic [DIV_WIDTH-1:0] div;       // effective clocks per bit (>= 2)
    logic [2:0]           last_bit;  // index of final data bit (4..7)
    logic                 par_en;
    logic                 par_bit;   // precomputed parity value
    logic                 two_stop;
  } frame_cfg_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok;
  logic          pop;
  logic [7:0]    head;

  assign wr_ok = wr_en & ~full;
  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];

  // Storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the dropped-write pulse; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en & full;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------- frame setup
  logic [7:0] data_mask;
  frame_cfg_t new_cfg;

  assign data_mask = 8'hFF >> (2'd3 - data_bits);

  // Build the settings to be latched alongside the popped byte.
  always_comb begin
    new_cfg          = '0;
    new_cfg.div      = (clk_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : clk_div;
    new_cfg.last_bit = 3'd4 + {1'b0, data_bits};
    new_cfg.par_en   = parity_en;
    new_cfg.par_bit  = (^(head & data_mask)) ^ parity_odd;
    new_cfg.two_stop = two_stop;
  end

  // ------------------------------------------------------------ TX engine
  state_t               state, state_n;
  frame_cfg_t           cfg;
  logic [DIV_WIDTH-1:0] cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           sh;
  logic                 tx_n, done_n;
  logic                 bit_end, last_data, frame_end;

  assign bit_end   = (cnt == cfg.div - DIV_WIDTH'(1));
  assign last_data = (bit_idx == cfg.last_bit);
  assign frame_end = bit_end &&
                     ((state == STOP1 && !cfg.two_stop) || state == STOP2);

  // State, serial line and done pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx    <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      tx    <= tx_n;
      done  <= done_n;
    end
  end

  // Next-state: each non-idle state lasts one bit period; chain frames when data waits.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (!empty) state_n = START;
      START:  if (bit_end) state_n = DATA;
      DATA:   if (bit_end && last_data) state_n = cfg.par_en ? PARITY : STOP1;
      PARITY: if (bit_end) state_n = STOP1;
      STOP1:  if (bit_end) state_n = cfg.two_stop ? STOP2 : (empty ? IDLE : START);
      STOP2:  if (bit_end) state_n = empty ? IDLE : START;
      default: state_n = IDLE;
    endcase
  end

  // Outputs: pop strobe, next line level and end-of-frame pulse.
  always_comb begin
    pop     = 1'b0;
    tx_n    = tx;
    done_n  = 1'b0;
    tx_busy = (state != IDLE);
    case (state)
      IDLE: begin
        if (!empty) begin
          pop  = 1'b1;
          tx_n = 1'b0;
        end else begin
          tx_n = 1'b1;
        end
      end
      START:  if (bit_end) tx_n = sh[0];
      DATA: begin
        if (bit_end) begin
          if (last_data) tx_n = cfg.par_en ? cfg.par_bit : 1'b1;
          else           tx_n = sh[1];
        end
      end
      PARITY: if (bit_end) tx_n = 1'b1;
      STOP1, STOP2: begin
        if (frame_end) begin
          done_n = 1'b1;
          if (!empty) begin
            pop  = 1'b1;
            tx_n = 1'b0;
          end else begin
            tx_n = 1'b1;
          end
        end else if (bit_end) begin
          tx_n = 1'b1;
        end
      end
      default: tx_n = 1'b1;
    endcase
  end

  // Bit timer, data shifter and latched frame settings.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      cfg     <= '0;
    end else if (pop) begin
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= head;
      cfg     <= new_cfg;
    end else if (state != IDLE) begin
      cnt <= bit_end ? '0 : cnt + DIV_WIDTH'(1);
      if (state == DATA && bit_end) begin
        sh      <= sh >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of the FIFO-fed UART transmitter (depth 4).
module tb_uart_tx_fifo;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        full, empty, overflow, tx_busy, done, tx;
  logic [2:0]  level;
  logic [15:0] clk_div = 16'd4;
  logic [1:0]  data_bits = 2'd3;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        two_stop = 1'b0;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .clk_div(clk_div), .data_bits(data_bits), .parity_en(parity_en),
    .parity_odd(parity_odd), .two_stop(two_stop),
    .tx_busy(tx_busy), .done(done), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the first START cycle; walks every clock of the frame.
  task automatic check_frame(input logic [7:0] d, input int nb, input logic pe,
                             input logic pbit, input logic ts, input int div,
                             input logic bb);
    logic bits [12];
    int   n;
    bits[0] = 1'b0;
    n = 1;
    for (int k = 0; k < nb; k++) begin
      bits[n] = d[k];
      n++;
    end
    if (pe) begin
      bits[n] = pbit;
      n++;
    end
    bits[n] = 1'b1;
    n++;
    if (ts) begin
      bits[n] = 1'b1;
      n++;
    end
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < div; c++) begin
        chk("frame_tx", 32'(tx), 32'(bits[i]));
        chk("frame_busy", 32'(tx_busy), 32'd1);
        chk("frame_done", 32'(done), (i == 0 && c == 0 && bb) ? 32'd1 : 32'd0);
        @(negedge clk);
      end
    end
    chk("end_done", 32'(done), 32'd1);
  endtask

  task automatic idle_after();
    chk("idle_busy", 32'(tx_busy), 32'd0);
    chk("idle_tx", 32'(tx), 32'd1);
    @(negedge clk);
    chk("idle_done_clr", 32'(done), 32'd0);
    chk("idle_tx2", 32'(tx), 32'd1);
    chk("idle_busy2", 32'(tx_busy), 32'd0);
  endtask

  // Single write into an idle, empty transmitter; ends on first START cycle.
  task automatic send(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
    chk("lat_tx_hi", 32'(tx), 32'd1);
    chk("lat_level", 32'(level), 32'd1);
    chk("lat_empty", 32'(empty), 32'd0);
    @(negedge clk);
    chk("lat_level_pop", 32'(level), 32'd0);
  endtask

  initial begin
    // Reset with a write presented; it must be ignored.
    wr_en = 1'b1;
    wr_data = 8'h55;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    reset = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    chk("post_rst_tx", 32'(tx), 32'd1);
    chk("post_rst_level", 32'(level), 32'd0);
    chk("post_rst_busy", 32'(tx_busy), 32'd0);

    // 8N1, divisor 4, 0xA5: 40 busy clocks.
    send(8'hA5);
    check_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    idle_after();

    // 7 data bits, odd parity, two stop bits, divisor 3, 0x41: parity 1.
    clk_div = 16'd3; data_bits = 2'd2; parity_en = 1'b1; parity_odd = 1'b1; two_stop = 1'b1;
    send(8'h41);
    check_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 3, 1'b0);
    idle_after();

    // Divisor 0 behaves as 2.
    clk_div = 16'd0; data_bits = 2'd3; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    send(8'h3C);
    check_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    idle_after();

    // Divisor 1 behaves as 2; 5 bits, even parity, upper bits ignored: 0xF3 -> 10011, parity 1.
    clk_div = 16'd1; data_bits = 2'd0; parity_en = 1'b1;
    send(8'hF3);
    check_frame(8'hF3, 5, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    idle_after();

    // data_bits changed mid-frame: current frame keeps 8, next one uses 5.
    clk_div = 16'd2; data_bits = 2'd3; parity_en = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h96;
    @(negedge clk);
    wr_data = 8'h5A;
    @(negedge clk);
    wr_en = 1'b0;
    chk("cfg_level", 32'(level), 32'd1);
    data_bits = 2'd0;
    check_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    chk("cfg_level2", 32'(level), 32'd0);
    check_frame(8'h5A, 5, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    idle_after();

    // Fill to full while a frame is in flight, then overflow once.
    data_bits = 2'd3;
    wr_en = 1'b1;
    wr_data = 8'h11;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    chk("ovf_start_tx", 32'(tx), 32'd0);
    chk("ovf_start_level", 32'(level), 32'd0);
    wr_en = 1'b1;
    wr_data = 8'h22;
    @(negedge clk);
    chk("fill1_level", 32'(level), 32'd1);
    chk("fill1_full", 32'(full), 32'd0);
    wr_data = 8'h33;
    @(negedge clk);
    chk("fill2_level", 32'(level), 32'd2);
    wr_data = 8'h44;
    @(negedge clk);
    chk("fill3_level", 32'(level), 32'd3);
    chk("fill3_full", 32'(full), 32'd0);
    wr_data = 8'h55;
    @(negedge clk);
    chk("fill4_level", 32'(level), 32'd4);
    chk("fill4_full", 32'(full), 32'd1);
    chk("fill4_ovf", 32'(overflow), 32'd0);
    wr_data = 8'h66;
    @(negedge clk);
    chk("drop_level", 32'(level), 32'd4);
    chk("drop_ovf", 32'(overflow), 32'd1);
    wr_en = 1'b0;
    @(negedge clk);
    chk("drop_ovf_clr", 32'(overflow), 32'd0);
    chk("drop_level2", 32'(level), 32'd4);
    for (int k = 0; k < 100 && done !== 1'b1; k++) @(negedge clk);
    chk("wait_done", 32'(done), 32'd1);
    chk("b2b_level3", 32'(level), 32'd3);
    chk("b2b_full", 32'(full), 32'd0);
    check_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    chk("b2b_level2", 32'(level), 32'd2);
    check_frame(8'h33, 8, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    chk("b2b_level1", 32'(level), 32'd1);
    check_frame(8'h44, 8, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    chk("b2b_level0", 32'(level), 32'd0);
    check_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    idle_after();

    // Reset mid-DATA with three entries queued.
    clk_div = 16'd4;
    wr_en = 1'b1;
    wr_data = 8'h02;
    @(negedge clk);
    wr_data = 8'h03;
    @(negedge clk);
    wr_data = 8'h04;
    @(negedge clk);
    wr_data = 8'h05;
    @(negedge clk);
    wr_en = 1'b0;
    chk("mr_level", 32'(level), 32'd3);
    repeat (3) @(negedge clk);
    chk("mr_busy", 32'(tx_busy), 32'd1);
    chk("mr_tx_bit0", 32'(tx), 32'd0);
    chk("mr_level2", 32'(level), 32'd3);
    reset = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h77;
    @(negedge clk);
    chk("mr_tx", 32'(tx), 32'd1);
    chk("mr_busy_clr", 32'(tx_busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_level0", 32'(level), 32'd0);
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_full", 32'(full), 32'd0);
    chk("mr_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("mr_quiet_tx", 32'(tx), 32'd1);
      chk("mr_quiet_busy", 32'(tx_busy), 32'd0);
      chk("mr_quiet_done", 32'(done), 32'd0);
      chk("mr_quiet_level", 32'(level), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
